bn_out_serializer: RTL and testbench
====================================

// Module: bn_out_serializer
// PURPOSE
//  Downstream neighbour of the multi-channel BN stage. Captures one full BN output vector
//  (SIZE fp16 elements, CHANNEL equal groups) and streams it one element per cycle to the
//  next layer. Optional ReLU is applied on the way out. Each element is tagged with its
//  channel, index and an end-of-vector flag.
//  A two-slot ping-pong buffer lets the next vector load while the current one drains.
// PARAMETERS
//  DATA_WIDTH  16  element width (IEEE fp16)
//  SIZE        8   elements per input vector; must be a multiple of CHANNEL
//  CHANNEL     2   channel groups per vector; group width is SIZE/CHANNEL elements
//  RELU_EN     1   1 = clamp negative elements to +0; 0 = pass through unchanged
// PORTS
//  clk        in   1                     single clock, rising edge
//  reset      in   1                     asynchronous, active-high
//  in_valid   in   1                     x holds a complete BN vector
//  in_ready   out  1                     a free slot exists (count<2), forced 0 while reset=1
//  x          in   [0:DATA_WIDTH*SIZE-1] element k at x[k*DATA_WIDTH +: DATA_WIDTH]
//  out_valid  out  1                     out_* hold a valid element
//  out_ready  in   1                     consumer accepts the element
//  out_data   out  DATA_WIDTH            element after optional ReLU
//  out_ch     out  max(1,clog2(CHANNEL)) channel = idx / (SIZE/CHANNEL)
//  out_idx    out  max(1,clog2(SIZE))    element index within the vector, 0..SIZE-1
//  out_last   out  1                     1 when out_idx == SIZE-1
// BEHAVIOUR
//  - Reset (async):
//    - count, wr_ptr, rd_ptr and idx go to 0; both slots are cleared.
//    - out_valid, out_data, out_ch, out_idx and out_last all read 0.
//  - Reset mid-stream: every buffered element is discarded and no partial vector resumes.
//    The first vector accepted after reset starts at idx 0.
//  - Input accept: in_valid && in_ready at an edge.
//    - x is stored whole into slot[wr_ptr], then wr_ptr toggles and count increments.
//    - x is sampled only at the accept edge and may change afterwards.
//  - Output release: out_valid && out_ready at an edge.
//    - If idx < SIZE-1: idx increments.
//    - If idx == SIZE-1: idx wraps to 0, rd_ptr toggles and count decrements.
//  - Accept and final release on the same edge: count is unchanged and both pointers toggle.
//    This gives full throughput: back-to-back vectors stream with no bubble.
//  - count == 2: in_ready = 0 and further vectors are held off by the producer.
//  - count == 0: out_valid = 0, and the out_* fields are don't-care apart from the reset values.
//  - out_valid = (count != 0). out_data, out_ch, out_idx and out_last are combinational
//    from slot[rd_ptr], element idx, and idx.
//  - Latency: a vector accepted into an empty block presents element 0 in the next cycle.
//    The last element appears SIZE-1 cycles later if out_ready is held at 1.
//  - out_* must remain stable while out_valid=1 and out_ready=0.
//  - ReLU (RELU_EN=1), decided on the sign bit only:
//    - sign=1 (including -0 and negative NaN/-Inf): output 16'h0000.
//    - sign=0: pass through unchanged, including +Inf and +NaN.
//  - Behaviour is undefined if SIZE is not a multiple of CHANNEL; that configuration is disallowed.
// TESTING
//  - Reset: assert reset mid-cycle -> out_valid=0, out_data=0 and in_ready=0 immediately.
//    Release reset -> in_ready=1 on the next cycle.
//  - Single vector (SIZE=8, CHANNEL=2, RELU_EN=1), x = {3C00,BC00,4000,8000,7C00,FC00,0001,8001},
//    out_ready=1 -> outputs 3C00,0000,4000,0000,7C00,0000,0001,0000.
//    out_ch = 0,0,0,0,1,1,1,1; out_last only on the 8th element.
//  - Same vector with RELU_EN=0 -> all 8 elements pass through bit-exact.
//  - Back-to-back: in_valid held high for 3 vectors, out_ready=1 -> 24 consecutive out_valid
//    cycles with no bubble. in_ready=0 exactly while count==2.
//  - Backpressure: out_ready toggles pseudo-randomly -> out_* stay stable while stalled.
//    No element is lost or duplicated, and in_ready deasserts after the 2nd vector.
//  - Reset mid-vector: assert reset after 3 of 8 elements -> nothing further is emitted.
//    The next vector starts at out_idx=0 with its own data.

Source files
------------

// File: rtl/bn_out_serializer.sv
// Two-slot ping-pong buffer that captures whole BN output vectors and streams them
// one fp16 element per cycle, tagged with channel/index/last, with optional ReLU.
module bn_out_serializer #(
  parameter  int DATA_WIDTH = 16,
  parameter  int SIZE       = 8,
  parameter  int CHANNEL    = 2,
  parameter  int RELU_EN    = 1,
  localparam int CH_W       = (CHANNEL > 1) ? $clog2(CHANNEL) : 1,
  localparam int IDX_W      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [0:DATA_WIDTH*SIZE-1] x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]            out_ch,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last
);

  localparam int GROUP = SIZE / CHANNEL;

  logic [1:0]            r_count;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_slot [2][SIZE];

  logic                  w_accept;
  logic                  w_release;
  logic                  w_final;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_elem;

  assign in_ready  = !reset && (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;
  assign w_last    = (r_idx == IDX_W'(SIZE - 1));
  assign w_final   = w_release && w_last;
  assign w_elem    = r_slot[r_rd_ptr][r_idx];

  // Fields are forced to zero while the buffer is empty so reset values hold.
  always_comb begin
    out_data = '0;
    out_ch   = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_data = w_elem;
      if ((RELU_EN != 0) && w_elem[DATA_WIDTH-1]) begin
        out_data = '0;
      end
      out_ch   = CH_W'(int'(r_idx) / GROUP);
      out_idx  = r_idx;
      out_last = w_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_idx    <= '0;
      for (int unsigned s = 0; s < 2; s++) begin
        for (int unsigned k = 0; k < SIZE; k++) begin
          r_slot[s][k] <= '0;
        end
      end
    end else begin
      if (w_accept) begin
        for (int unsigned k = 0; k < SIZE; k++) begin
          r_slot[r_wr_ptr][k] <= x[k*DATA_WIDTH +: DATA_WIDTH];
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_release) begin
        if (w_last) begin
          r_idx    <= '0;
          r_rd_ptr <= ~r_rd_ptr;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      // Simultaneous accept and final release leaves occupancy unchanged.
      unique case ({w_accept, w_final})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bn_out_serializer.sv
// Randomized/directed bench for bn_out_serializer against a vector-queue reference model;
// a second instance with ReLU disabled checks bit-exact pass-through.
module tb_bn_out_serializer;

  localparam int DW = 16;
  localparam int SZ = 8;
  localparam int CH = 2;

  typedef logic [0:DW*SZ-1] pvec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  pvec_t       x = '0;

  logic        in_ready, out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [0:0]  out_ch;
  logic [2:0]  out_idx;
  logic        in_ready0, out_valid0, out_last0;
  logic [DW-1:0] out_data0;
  logic [0:0]  out_ch0;
  logic [2:0]  out_idx0;

  int checks = 0;
  int errors = 0;

  pvec_t mq[$];
  int    pos = 0;
  int    emitted = 0;
  bit    dir_on = 1'b0;
  int    dir_n = 0;
  logic [DW-1:0] dir_relu [8];
  logic [DW-1:0] dir_raw  [8];

  always #5 clk = ~clk;

  bn_out_serializer #(.DATA_WIDTH(DW), .SIZE(SZ), .CHANNEL(CH), .RELU_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_idx(out_idx), .out_last(out_last));

  bn_out_serializer #(.DATA_WIDTH(DW), .SIZE(SZ), .CHANNEL(CH), .RELU_EN(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .x(x),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ch(out_ch0), .out_idx(out_idx0), .out_last(out_last0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pvec_t rnd_vec();
    pvec_t v;
    for (int k = 0; k < SZ; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // One clock: compare at negedge, then advance the model past the posedge.
  task automatic tick(output bit acc, output bit rel);
    pvec_t hv;
    pvec_t xin;
    logic [DW-1:0] raw;
    @(negedge clk);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_ready0", in_ready0, mq.size() < 2);
    chk("out_valid0", out_valid0, mq.size() != 0);
    if (mq.size() != 0) begin
      hv  = mq[0];
      raw = hv[pos*DW +: DW];
      chk("out_data", out_data, raw[DW-1] ? '0 : raw);
      chk("out_data_norelu", out_data0, raw);
      chk("out_idx", out_idx, pos);
      chk("out_ch", out_ch, pos / (SZ / CH));
      chk("out_last", out_last, pos == SZ - 1);
      chk("out_ch0", out_ch0, pos / (SZ / CH));
    end
    acc = in_valid && (mq.size() < 2);
    rel = (mq.size() != 0) && out_ready;
    xin = x;
    if (dir_on && rel && dir_n < 8) begin
      chk("dir_relu", out_data, dir_relu[dir_n]);
      chk("dir_raw", out_data0, dir_raw[dir_n]);
      dir_n++;
    end
    @(posedge clk);
    #1;
    if (rel) begin
      emitted++;
      pos++;
      if (pos == SZ) begin
        void'(mq.pop_front());
        pos = 0;
      end
    end
    if (acc) mq.push_back(xin);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_valid0", out_valid0, 0);
    mq.delete();
    pos = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    bit acc, rel;
    int sent, vcnt, cyc, base;
    pvec_t dv;

    dv = {16'h3C00, 16'hBC00, 16'h4000, 16'h8000, 16'h7C00, 16'hFC00, 16'h0001, 16'h8001};
    for (int k = 0; k < 8; k++) begin
      dir_raw[k]  = dv[k*DW +: DW];
      dir_relu[k] = (k % 2 == 0) ? dv[k*DW +: DW] : 16'h0000;
    end

    #2;
    do_reset();
    tick(acc, rel);

    // Directed single vector with ReLU and pass-through
    x = dv; in_valid = 1'b1; out_ready = 1'b1; dir_on = 1'b1;
    tick(acc, rel);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick(acc, rel);
    chk("dir_count", dir_n, 8);
    chk("dir_drained", mq.size(), 0);
    dir_on = 1'b0;

    // Back-to-back: three vectors, no bubble
    sent = 0; vcnt = 0; cyc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (sent == 3 && mq.size() == 0) break;
      if (sent == 3) in_valid = 1'b0;
      else x = rnd_vec();
      if (mq.size() != 0) vcnt++;
      tick(acc, rel);
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_valid_cycles", vcnt, 24);
    chk("b2b_total_cycles", cyc, 25);

    // Backpressure with random in_valid/out_ready
    sent = 0; base = emitted;
    for (int i = 0; i < 600; i++) begin
      if (sent == 4 && mq.size() == 0) break;
      x = rnd_vec();
      in_valid = (sent < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      tick(acc, rel);
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("bp_sent", sent, 4);
    chk("bp_emitted", emitted - base, 32);

    // Reset after three elements of a vector
    out_ready = 1'b1; x = rnd_vec(); in_valid = 1'b1;
    tick(acc, rel);
    in_valid = 1'b0;
    base = emitted;
    for (int i = 0; i < 20 && emitted - base < 3; i++) tick(acc, rel);
    chk("mid_emitted", emitted - base, 3);
    do_reset();
    base = emitted;
    for (int i = 0; i < 4; i++) tick(acc, rel);
    chk("post_rst_silent", emitted - base, 0);
    x = rnd_vec(); in_valid = 1'b1;
    tick(acc, rel);
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick(acc, rel);
    chk("post_rst_emitted", emitted - base, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
